// File: rtl/hsv_pkg.sv
// rtl/hsv_pkg.sv - shared states, constants and hue wrap helper for the RGB-to-HSV converter
package hsv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MINMAX = 3'd1,
        ST_DIV_S  = 3'd2,
        ST_DIV_H  = 3'd3,
        ST_DIV_V  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int HUE_MAX    = 360;
    localparam int PCT_MAX    = 100;
    localparam int HUE_BASE_R = 0;
    localparam int HUE_BASE_G = 120;
    localparam int HUE_BASE_B = 240;
    localparam int LATENCY    = 52;
    localparam int DIV_W      = 16;

    // Sector base plus signed offset, folded back into 0..359.
    function automatic logic [8:0] hue_wrap(input logic [8:0] base,
                                            input logic [8:0] q,
                                            input logic       neg);
        logic [9:0] t;
        if (!neg) begin
            t = {1'b0, base} + {1'b0, q};
        end else begin
            t = {1'b0, base} + 10'(HUE_MAX) - {1'b0, q};
            if (t >= 10'(HUE_MAX)) begin
                t = t - 10'(HUE_MAX);
            end
        end
        return t[8:0];
    endfunction

endpackage

// File: rtl/hsv_div_serial.sv
// rtl/hsv_div_serial.sv - unsigned restoring divider, 16-bit dividend by 8-bit divisor, one bit per cycle
module hsv_div_serial
    import hsv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [7:0]       divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [7:0]       remainder
);

    logic [DIV_W-1:0] quot_q;
    logic [8:0]       rem_q;
    logic [7:0]       dsr_q;
    logic [4:0]       cnt_q;
    logic             done_q;

    logic [8:0]       rem_shift;
    logic [9:0]       diff;
    logic             fits;

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        rem_shift = {rem_q[7:0], quot_q[DIV_W-1]};
        diff      = {1'b0, rem_shift} - {2'b00, dsr_q};
        fits      = ~diff[9];
    end

    // Load on start, then iterate DIV_W times; done rises with the last bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quot_q <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            quot_q <= dividend;
            rem_q  <= '0;
            dsr_q  <= divisor;
            cnt_q  <= 5'(DIV_W);
            done_q <= 1'b0;
        end else if (cnt_q != 5'd0) begin
            cnt_q  <= cnt_q - 5'd1;
            quot_q <= {quot_q[DIV_W-2:0], fits};
            rem_q  <= fits ? diff[8:0] : rem_shift;
            if (cnt_q == 5'd1) begin
                done_q <= 1'b1;
            end
        end
    end

    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q[7:0];

endmodule

// File: rtl/rgb_to_hsv.sv
// rtl/rgb_to_hsv.sv - multi-cycle RGB to HSV converter sharing one serial divider
module rgb_to_hsv
    import hsv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] R,
    input  logic [7:0] G,
    input  logic [7:0] B,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] Hue,
    output logic [8:0] Saturation,
    output logic [8:0] Value
);

    state_t state;

    logic [7:0] r_q, g_q, b_q;
    logic [7:0] mx_q, dl_q, abs_q;
    logic [8:0] base_q;
    logic       neg_q;
    logic [8:0] sat_q, hue_q;

    logic [7:0] mx, mn, dl, num_abs;
    logic [8:0] base;
    logic       num_neg;

    logic             div_start;
    logic [DIV_W-1:0] div_dividend;
    logic [7:0]       div_divisor;
    logic             div_done;
    logic [DIV_W-1:0] div_quot;
    logic [7:0]       div_rem;
    logic [8:0]       val_next;

    // Extremes, spread and dominant channel of the latched pixel (ties favour R, then G).
    always_comb begin
        mx = r_q;
        if (g_q > mx) mx = g_q;
        if (b_q > mx) mx = b_q;
        mn = r_q;
        if (g_q < mn) mn = g_q;
        if (b_q < mn) mn = b_q;
        dl = mx - mn;
        if (r_q >= g_q && r_q >= b_q) begin
            base    = 9'(HUE_BASE_R);
            num_neg = (g_q < b_q);
            num_abs = num_neg ? (b_q - g_q) : (g_q - b_q);
        end else if (g_q >= b_q) begin
            base    = 9'(HUE_BASE_G);
            num_neg = (b_q < r_q);
            num_abs = num_neg ? (r_q - b_q) : (b_q - r_q);
        end else begin
            base    = 9'(HUE_BASE_B);
            num_neg = (r_q < g_q);
            num_abs = num_neg ? (g_q - r_q) : (r_q - g_q);
        end
    end

    // Divider operand mux: each divide is launched on the edge that enters its state.
    always_comb begin
        div_start    = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        case (state)
            ST_MINMAX: begin
                div_start    = 1'b1;
                div_dividend = 16'(dl) * 16'(PCT_MAX);
                div_divisor  = mx;
            end
            ST_DIV_S: begin
                div_start    = div_done;
                div_dividend = 16'(abs_q) * 16'd60;
                div_divisor  = dl_q;
            end
            ST_DIV_H: begin
                div_start    = div_done;
                div_dividend = {7'd0, mx_q, 1'b0};
                div_divisor  = 8'd5;
            end
            default: begin
                div_start = 1'b0;
            end
        endcase
    end

    // Value saturates at full scale because 250 counts already map to 100 percent.
    always_comb begin
        val_next = (div_quot > 16'(PCT_MAX)) ? 9'(PCT_MAX) : div_quot[8:0];
    end

    hsv_div_serial u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Control FSM with registered handshakes; S and H are staged so all outputs move together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            Hue        <= '0;
            Saturation <= '0;
            Value      <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            mx_q       <= '0;
            dl_q       <= '0;
            abs_q      <= '0;
            base_q     <= '0;
            neg_q      <= 1'b0;
            sat_q      <= '0;
            hue_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_q      <= R;
                        g_q      <= G;
                        b_q      <= B;
                        in_ready <= 1'b0;
                        state    <= ST_MINMAX;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_MINMAX: begin
                    mx_q   <= mx;
                    dl_q   <= dl;
                    abs_q  <= num_abs;
                    base_q <= base;
                    neg_q  <= num_neg;
                    state  <= ST_DIV_S;
                end
                ST_DIV_S: begin
                    if (div_done) begin
                        sat_q <= (mx_q == 8'd0) ? 9'd0 : div_quot[8:0];
                        state <= ST_DIV_H;
                    end
                end
                ST_DIV_H: begin
                    if (div_done) begin
                        hue_q <= (dl_q == 8'd0) ? 9'd0 : hue_wrap(base_q, div_quot[8:0], neg_q);
                        state <= ST_DIV_V;
                    end
                end
                ST_DIV_V: begin
                    if (div_done) begin
                        Saturation <= sat_q;
                        Hue        <= hue_q;
                        Value      <= val_next;
                        out_valid  <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_to_hsv.sv
// tb/tb_rgb_to_hsv.sv - self-checking bench for rgb_to_hsv
module tb_rgb_to_hsv;

    localparam int EXP_LAT = 52;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] R, G, B;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] Hue, Saturation, Value;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_to_hsv dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .R          (R),
        .G          (G),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Hue        (Hue),
        .Saturation (Saturation),
        .Value      (Value)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: textbook HSV with integer floor division.
    task automatic model(input int r, input int g, input int b,
                         output int h, output int s, output int v);
        int mx, mn, d, n, base, q;
        mx = (r > g) ? r : g;
        mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g;
        mn = (mn < b) ? mn : b;
        d  = mx - mn;
        s  = (mx == 0) ? 0 : (d * 100) / mx;
        v  = (mx * 2) / 5;
        if (v > 100) v = 100;
        if (d == 0) begin
            h = 0;
        end else begin
            if (r == mx) begin n = g - b; base = 0;   end
            else if (g == mx) begin n = b - r; base = 120; end
            else begin n = r - g; base = 240; end
            q = (60 * ((n < 0) ? -n : n)) / d;
            h = (n >= 0) ? base + q : (base + 360 - q) % 360;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the result appears.
    task automatic send(input string tag, input int r, input int g, input int b,
                        input int eh, input int es, input int ev);
        int k, lat;
        R = 8'(r); G = 8'(g); B = 8'(b);
        in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 200) begin
            @(posedge clk); #1; k++;
        end
        chk({tag, "_accept_wait"}, (k < 200) ? 1 : 0, 1);
        @(posedge clk); #1;
        chk({tag, "_in_ready_drop"}, in_ready, 0);
        in_valid = 1'b0;
        R = 8'($urandom); G = 8'($urandom); B = 8'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_latency"}, lat, EXP_LAT);
        chk({tag, "_hue"}, Hue, eh);
        chk({tag, "_sat"}, Saturation, es);
        chk({tag, "_val"}, Value, ev);
    endtask

    task automatic handshake(input string tag, input int eh, input int es, input int ev);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_hs_valid_low"}, out_valid, 0);
        chk({tag, "_hs_ready_high"}, in_ready, 1);
        chk({tag, "_hs_hue_kept"}, Hue, eh);
        chk({tag, "_hs_sat_kept"}, Saturation, es);
        chk({tag, "_hs_val_kept"}, Value, ev);
    endtask

    int dir_tab [10][6] = '{
        '{255,   0,   0,   0, 100, 100},
        '{  0, 255,   0, 120, 100, 100},
        '{  0,   0, 255, 240, 100, 100},
        '{255, 255,   0,  60, 100, 100},
        '{  0,   0,   0,   0,   0,   0},
        '{128, 128, 128,   0,   0,  51},
        '{250, 250, 250,   0,   0, 100},
        '{255,   0, 128, 330, 100, 100},
        '{255,   0,   1,   0, 100, 100},
        '{100,  50, 200, 260,  75,  80}
    };

    initial begin
        int r, g, b, h, s, v, seen;

        // Reset held with a pixel offered.
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        R = 8'd255; G = 8'd0; B = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_hue", Hue, 0);
        chk("rst_sat", Saturation, 0);
        chk("rst_val", Value, 0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", in_ready, 0);
        @(posedge clk); #1;
        chk("rel_in_ready_rise", in_ready, 1);
        chk("rel_no_out_valid", out_valid, 0);

        // Directed primaries, degenerate and wrap cases.
        for (int i = 0; i < 10; i++) begin
            send($sformatf("dir%0d", i), dir_tab[i][0], dir_tab[i][1], dir_tab[i][2],
                 dir_tab[i][3], dir_tab[i][4], dir_tab[i][5]);
            handshake($sformatf("dir%0d", i), dir_tab[i][3], dir_tab[i][4], dir_tab[i][5]);
        end

        // Random pixels against the reference.
        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 255));
            g = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if (i % 6 == 0) g = r;
            if (i % 6 == 1) b = r;
            model(r, g, b, h, s, v);
            send($sformatf("rnd%0d", i), r, g, b, h, s, v);
            handshake($sformatf("rnd%0d", i), h, s, v);
        end

        // Backpressure: result must hold while inputs churn.
        out_ready = 1'b0;
        send("bp", 100, 50, 200, 260, 75, 80);
        for (int i = 0; i < 10; i++) begin
            R = 8'($urandom); G = 8'($urandom); B = 8'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hue", Hue, 260);
            chk("bp_sat", Saturation, 75);
            chk("bp_val", Value, 80);
        end
        in_valid = 1'b0;
        handshake("bp", 260, 75, 80);
        r = int'($urandom_range(0, 255));
        g = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        model(r, g, b, h, s, v);
        send("bp_next", r, g, b, h, s, v);
        handshake("bp_next", h, s, v);

        // Reset in mid-flight discards the pixel.
        R = 8'd10; G = 8'd200; B = 8'd30; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("mid_accepted", in_ready, 0);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_hue", Hue, 0);
        chk("mid_rst_sat", Saturation, 0);
        chk("mid_rst_val", Value, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        chk("mid_no_result", seen, 0);
        send("post_rst", 0, 255, 0, 120, 100, 100);
        handshake("post_rst", 120, 100, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_to_hsv.md
# rgb_to_hsv

Converts one 8-bit-per-channel RGB pixel into the Hue/Saturation/Value format consumed by the HSV-to-RGB block, so the two can run back-to-back in a colour-adjust loop. Single-issue, multi-cycle: a pixel is accepted on a valid/ready handshake, and one shared serial divider evaluates Saturation, Hue and Value in turn. The result is held on a valid/ready output until taken. Latency is fixed and independent of data.

## Interface
- No parameters. Constants come from `hsv_pkg`.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (low) clears all state immediately.
- `in_valid`  in  1  R/G/B valid.
- `in_ready`  out  1  block can accept a pixel.
- `R`, `G`, `B`  in  8 each  unsigned 0..255.
- `out_valid`  out  1  Hue/Saturation/Value valid.
- `out_ready`  in  1  downstream takes result.
- `Hue`  out  9  degrees 0..359.
- `Saturation`  out  9  percent 0..100.
- `Value`  out  9  percent 0..100; 250 RGB counts correspond to 100.

## Operation
- **States:**
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, latch R/G/B and go to MINMAX.
  - MINMAX: 1 cycle. Compute max, min, delta = max - min, dominant channel and signed numerator.
  - DIV_S, DIV_H, DIV_V: 17 cycles each (1 load + 16 iterations).
  - DONE: `out_valid`=1. Go to IDLE on `out_ready`.
- **Dominant channel:** priority R > G > B on ties.
  - R dominant: num = G - B, base = 0.
  - G dominant: num = B - R, base = 120.
  - B dominant: num = R - G, base = 240.
- **Saturation** = floor(delta*100 / max). Forced to 0 when max = 0.
- **Hue:**
  - q = floor(60*|num| / delta), q in 0..60.
  - num >= 0: Hue = base + q.
  - num < 0: Hue = (base + 360 - q) mod 360.
  - delta = 0: Hue = 0.
- **Value** = min(floor(max*2 / 5), 100).
- **Widths:**
  - Dividends are zero-extended to 16 bits: delta*100 <= 25500, 60*|num| <= 15300, max*2 <= 510.
  - Divisors are 8 bits.
  - Results are truncated to 9 bits after clamp/wrap.
- **Divide by zero:** divisions always run. A zero divisor's result is discarded and the override above applies, so latency stays constant.
- **In-flight pixels:** one at most. `in_ready` is 0 in every state except IDLE. No input is accepted in DONE, even with `out_ready`=1.

## Timing
- **Reset values:** `in_ready`=0, `out_valid`=0, Hue=Saturation=Value=0, state IDLE.
  - `in_ready` is registered and rises on the first clock edge after `reset` deasserts.
- **Accepting edge (edge 0):** the edge where `in_valid && in_ready`. `in_ready` falls after edge 0.
- **Latency:** `out_valid` and all three outputs update together on edge 52. LATENCY = 52 = 1 + 3*17.
- **Output hold:** while `out_valid && !out_ready`, outputs and `out_valid` stay stable.
- **Handshake exit:** on the edge where `out_valid && out_ready`, `out_valid` falls and `in_ready` rises. Next accept is possible on the edge after that. Throughput is 1 pixel per 54 cycles minimum.
- **Output registers:** keep last values after handshake until the next result.
- **R/G/B after edge 0:** ignored.
- **Reset mid-operation (any state):** result is discarded, outputs return to reset values, and no `out_valid` pulse follows.
- **`in_valid` low in IDLE:** no state change.

## Structure
- **`hsv_pkg`:**
  - State enum.
  - HUE_MAX=360, PCT_MAX=100, HUE_BASE_R/G/B = 0/120/240.
  - LATENCY=52, DIV_W=16.
- **Sub-module `hsv_div_serial`:**
  - Unsigned restoring divider: 16-bit dividend, 8-bit divisor, `start`/`done`, quotient and remainder, 1 bit per cycle.
  - Same `clk`/`reset`.
  - Instantiated once and time-shared by DIV_S, DIV_H and DIV_V.
- **Top level:** FSM, min/max/priority logic, operand mux, result registers, overrides.

## Test plan
- Reset held low with `in_valid`=1, then released: all outputs 0 during reset; `in_ready` rises 1 edge after release; no accept before that.
- Primaries:
  - (255,0,0) -> H0 S100 V100, `out_valid` exactly 52 edges after accept.
  - (0,255,0) -> H120 S100 V100.
  - (0,0,255) -> H240 S100 V100.
  - (255,255,0) -> H60 S100 V100.
- Degenerate inputs (zero-divisor overrides):
  - (0,0,0) -> 0/0/0.
  - (128,128,128) -> H0 S0 V51.
  - (250,250,250) -> H0 S0 V100.
- Negative numerator and wrap:
  - (255,0,128) -> H330 S100 V100.
  - (255,0,1) -> H0 (q=0 wrap).
  - (100,50,200) -> H260 S75 V80.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`, toggling R/G/B and `in_valid` -> outputs stable, `in_ready`=0, exactly one handshake. Then the next pixel is accepted 1 edge later.
- Reset asserted 20 edges after accept, released 3 cycles later -> `out_valid` never asserts for that pixel. A new pixel (0,255,0) afterwards -> H120 S100 V100 at normal latency.
